// File: rtl/rv32_alu_decoder_if.sv
// ALU opcode package plus the two bus bundles of the RV32I decode stage:
// the fetch/register-read side and the issue side towards rv32_alu.
package rv32_alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NEQ  = 4'd11,
        ALU_SBT  = 4'd12,
        ALU_SBTU = 4'd13
    } rv32_alu_op_t;
endpackage

interface rv32_instr_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    modport master (output instr_valid, instr, pc, rs1_data, rs2_data, input instr_ready);
    modport slave  (input instr_valid, instr, pc, rs1_data, rs2_data, output instr_ready);
endinterface

interface rv32_alu_if;
    import rv32_alu_pkg::*;

    logic         alu_valid;
    logic         alu_ready;
    rv32_alu_op_t alu_opcode;
    logic [31:0]  alu_rs1;
    logic [31:0]  alu_rs2;
    logic [4:0]   rd;
    logic [31:0]  br_offset;
    logic         is_branch;
    logic         illegal;

    modport master (output alu_valid, alu_opcode, alu_rs1, alu_rs2, rd, br_offset, is_branch, illegal,
                    input alu_ready);
    modport slave  (input alu_valid, alu_opcode, alu_rs1, alu_rs2, rd, br_offset, is_branch, illegal,
                    output alu_ready);
endinterface

// File: rtl/rv32_alu_decoder.sv
// RV32I decode into rv32_alu issue packets; 1-cycle latency through a 2-entry OUT/SKID buffer.
// Backpressure: instr_ready is a flop and drops only while both entries hold packets.
module rv32_alu_decoder
    import rv32_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    rv32_instr_if.slave instr_bus,
    rv32_alu_if.master  alu_bus
);

    typedef struct packed {
        rv32_alu_op_t    op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic [XLEN-1:0] br_offset;
        logic            is_branch;
        logic            illegal;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic rv32_alu_op_t arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] shamt;
    logic            ill;
    pkt_t            dec;

    assign opc   = instr_bus.instr[6:0];
    assign f3    = instr_bus.instr[14:12];
    assign f7    = instr_bus.instr[31:25];
    assign imm_i = {{(XLEN-12){instr_bus.instr[31]}}, instr_bus.instr[31:20]};
    assign imm_u = {instr_bus.instr[31:12], 12'b0};
    assign imm_b = {{(XLEN-12){instr_bus.instr[31]}}, instr_bus.instr[7],
                    instr_bus.instr[30:25], instr_bus.instr[11:8], 1'b0};
    assign shamt = {{(XLEN-5){1'b0}}, instr_bus.instr[24:20]};

    always_comb begin
        dec    = '0;
        ill    = 1'b0;
        dec.a  = instr_bus.rs1_data;
        dec.rd = instr_bus.instr[11:7];
        case (opc)
            OPC_OP: begin
                dec.b = instr_bus.rs2_data;
                if (f7 == 7'h00)                      dec.op = arith_op(f3);
                else if (f7 == 7'h20 && f3 == 3'b000) dec.op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'b101) dec.op = ALU_SRA;
                else                                  ill = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.op = arith_op(f3);
                dec.b  = imm_i;
                // Shift-immediates reuse instr[31:25] as a function field, not immediate bits.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.b = shamt;
                    if (f3 == 3'b101 && f7 == 7'h20) dec.op = ALU_SRA;
                    else if (f7 != 7'h00)            ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.a = '0;
                dec.b = imm_u;
            end
            OPC_AUIPC: begin
                dec.a = instr_bus.pc;
                dec.b = imm_u;
            end
            OPC_BRANCH: begin
                dec.b         = instr_bus.rs2_data;
                dec.rd        = 5'd0;
                dec.is_branch = 1'b1;
                dec.br_offset = imm_b;
                case (f3)
                    3'b000:  dec.op = ALU_EQ;
                    3'b001:  dec.op = ALU_NEQ;
                    3'b100:  dec.op = ALU_SLT;
                    3'b101:  dec.op = ALU_SBT;
                    3'b110:  dec.op = ALU_SLTU;
                    3'b111:  dec.op = ALU_SBTU;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    state_t state;
    state_t state_nx;
    logic   rdy_q;
    pkt_t   out_q;
    pkt_t   skid_q;
    logic   xfer;
    logic   cons;
    logic   load_out;
    logic   load_skid;
    logic   out_from_skid;

    assign xfer = instr_bus.instr_valid & rdy_q;
    assign cons = (state != ST_EMPTY) & alu_bus.alu_ready;

    always_comb begin
        state_nx      = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer) begin
                        state_nx = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (xfer && cons) begin
                        load_out = 1'b1;
                    end else if (xfer) begin
                        state_nx  = ST_FULL;
                        load_skid = 1'b1;
                    end else if (cons) begin
                        state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (cons) begin
                        state_nx      = ST_ONE;
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            rdy_q  <= 1'b1;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx != ST_FULL);
            if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign instr_bus.instr_ready = rdy_q;
    assign alu_bus.alu_valid     = (state != ST_EMPTY);
    assign alu_bus.alu_opcode    = out_q.op;
    assign alu_bus.alu_rs1       = out_q.a;
    assign alu_bus.alu_rs2       = out_q.b;
    assign alu_bus.rd            = out_q.rd;
    assign alu_bus.br_offset     = out_q.br_offset;
    assign alu_bus.is_branch     = out_q.is_branch;
    assign alu_bus.illegal       = out_q.illegal;

endmodule

// File: tb/tb_rv32_alu_decoder.sv
// Randomized and directed bench for rv32_alu_decoder against an instruction-level model
// with a FIFO scoreboard of expected packets.
module tb_rv32_alu_decoder;
    import rv32_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    rv32_instr_if ib ();
    rv32_alu_if   ob ();

    rv32_alu_decoder #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .instr_bus (ib),
        .alu_bus   (ob)
    );

    typedef struct {
        rv32_alu_op_t op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [4:0]   rd;
        logic [31:0]  off;
        logic         br;
        logic         ill;
    } exp_t;

    rv32_alu_op_t arith_tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    rv32_alu_op_t br_tbl    [8] = '{ALU_EQ, ALU_NEQ, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SBT, ALU_SLTU, ALU_SBTU};

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   tracking = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural meaning of one instruction; immediates built by weighting bit fields.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        bit         bad = 1'b1;
        logic [6:0] major = i[6:0];
        int         f3 = int'(i[14:12]);
        int         f7 = int'(i[31:25]);
        logic [31:0] imm_i = $signed(i) >>> 20;
        logic [31:0] imm_u = i & 32'hFFFF_F000;
        int         boff = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - int'(i[31]) * 4096;
        e.op = ALU_ADD; e.a = r1; e.b = 32'd0; e.rd = i[11:7]; e.off = 32'd0; e.br = 1'b0; e.ill = 1'b0;
        if (major == 7'h33) begin
            e.b = r2;
            if (f7 == 0) begin
                e.op = arith_tbl[f3]; bad = 1'b0;
            end else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin
                e.op = (f3 == 0) ? ALU_SUB : ALU_SRA; bad = 1'b0;
            end
        end else if (major == 7'h13) begin
            if (f3 == 1 || f3 == 5) begin
                e.b  = {27'd0, i[24:20]};
                e.op = (f7 == 'h20) ? ALU_SRA : arith_tbl[f3];
                bad  = !(f7 == 0 || (f7 == 'h20 && f3 == 5));
            end else begin
                e.b = imm_i; e.op = arith_tbl[f3]; bad = 1'b0;
            end
        end else if (major == 7'h37) begin
            e.a = 32'd0; e.b = imm_u; bad = 1'b0;
        end else if (major == 7'h17) begin
            e.a = pc; e.b = imm_u; bad = 1'b0;
        end else if (major == 7'h63 && f3 != 2 && f3 != 3) begin
            e.op = br_tbl[f3]; e.b = r2; e.rd = 5'd0; e.br = 1'b1; e.off = 32'(boff); bad = 1'b0;
        end
        if (bad) begin
            e.op = ALU_ADD; e.a = 32'd0; e.b = 32'd0; e.rd = 5'd0; e.off = 32'd0; e.br = 1'b0; e.ill = 1'b1;
        end
        return e;
    endfunction

    // One clock: check against the scoreboard at negedge, update it, return just after posedge.
    task automatic step();
        bit cons;
        bit xfer;
        @(negedge clk);
        if (tracking) begin
            check("alu_valid", 32'(ob.alu_valid), 32'(q.size() != 0));
            check("instr_ready", 32'(ib.instr_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                check("opcode", 32'(ob.alu_opcode), 32'(q[0].op));
                check("rs1", ob.alu_rs1, q[0].a);
                check("rs2", ob.alu_rs2, q[0].b);
                check("rd", 32'(ob.rd), 32'(q[0].rd));
                check("br_offset", ob.br_offset, q[0].off);
                check("is_branch", 32'(ob.is_branch), 32'(q[0].br));
                check("illegal", 32'(ob.illegal), 32'(q[0].ill));
            end
            cons = (q.size() != 0) && ob.alu_ready;
            xfer = ib.instr_valid && (q.size() < 2);
            if (rst) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (flush) q.delete();
                else if (xfer) q.push_back(model(ib.instr, ib.pc, ib.rs1_data, ib.rs2_data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(ob.alu_valid), 32'd0);
        check({tag, "_ready"}, 32'(ib.instr_ready), 32'd1);
        check({tag, "_opcode"}, 32'(ob.alu_opcode), 32'(ALU_ADD));
        check({tag, "_rs1"}, ob.alu_rs1, 32'd0);
        check({tag, "_rs2"}, ob.alu_rs2, 32'd0);
        check({tag, "_rd"}, 32'(ob.rd), 32'd0);
        check({tag, "_off"}, ob.br_offset, 32'd0);
        check({tag, "_br"}, 32'(ob.is_branch), 32'd0);
        check({tag, "_ill"}, 32'(ob.illegal), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h37;
            5:       w[6:0] = 7'h17;
            6:       w[6:0] = 7'h63;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0, 1:    w[31:25] = 7'h00;
            2:       w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    typedef struct {
        logic [31:0]  instr;
        logic [31:0]  pc;
        rv32_alu_op_t op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [4:0]   rd;
        logic [31:0]  off;
        logic         br;
        logic         ill;
    } dir_t;

    dir_t dir_tbl [10] = '{
        '{32'h002081B3, 32'h0,   ALU_ADD, 32'h10,  32'h3,          5'd3, 32'd0, 1'b0, 1'b0},
        '{32'h402081B3, 32'h0,   ALU_SUB, 32'h10,  32'h3,          5'd3, 32'd0, 1'b0, 1'b0},
        '{32'hFFF08293, 32'h0,   ALU_ADD, 32'h10,  32'hFFFFFFFF,   5'd5, 32'd0, 1'b0, 1'b0},
        '{32'h4030D293, 32'h0,   ALU_SRA, 32'h10,  32'h3,          5'd5, 32'd0, 1'b0, 1'b0},
        '{32'h123453B7, 32'h100, ALU_ADD, 32'h0,   32'h12345000,   5'd7, 32'd0, 1'b0, 1'b0},
        '{32'h12345397, 32'h100, ALU_ADD, 32'h100, 32'h12345000,   5'd7, 32'd0, 1'b0, 1'b0},
        '{32'h00208463, 32'h100, ALU_EQ,  32'h10,  32'h3,          5'd0, 32'd8, 1'b1, 1'b0},
        '{32'h0020D463, 32'h100, ALU_SBT, 32'h10,  32'h3,          5'd0, 32'd8, 1'b1, 1'b0},
        '{32'h00000000, 32'h0,   ALU_ADD, 32'h0,   32'h0,          5'd0, 32'd0, 1'b0, 1'b1},
        '{32'h02208233, 32'h0,   ALU_ADD, 32'h0,   32'h0,          5'd0, 32'd0, 1'b0, 1'b1}
    };

    initial begin
        rst = 1'b1; flush = 1'b0;
        ib.instr_valid = 1'b0; ib.instr = 32'd0; ib.pc = 32'd0; ib.rs1_data = 32'd0; ib.rs2_data = 32'd0;
        ob.alu_ready = 1'b0;
        step(); step();
        rst = 1'b0; tracking = 1'b1;
        #3 check_reset_vals("init");

        // Directed decode, back-to-back with the ALU always ready.
        ob.alu_ready = 1'b1; ib.rs1_data = 32'h10; ib.rs2_data = 32'h3; ib.instr_valid = 1'b1;
        foreach (dir_tbl[k]) begin
            ib.instr = dir_tbl[k].instr; ib.pc = dir_tbl[k].pc;
            step();
            #3;
            check("dir_valid", 32'(ob.alu_valid), 32'd1);
            check("dir_opcode", 32'(ob.alu_opcode), 32'(dir_tbl[k].op));
            check("dir_rs1", ob.alu_rs1, dir_tbl[k].a);
            check("dir_rs2", ob.alu_rs2, dir_tbl[k].b);
            check("dir_rd", 32'(ob.rd), 32'(dir_tbl[k].rd));
            check("dir_off", ob.br_offset, dir_tbl[k].off);
            check("dir_br", 32'(ob.is_branch), 32'(dir_tbl[k].br));
            check("dir_ill", 32'(ob.illegal), 32'(dir_tbl[k].ill));
        end
        ib.instr_valid = 1'b0;
        step(); step();

        // Backpressure: three ADDIs with immediates 1, 2, 3 and the ALU stalled.
        ob.alu_ready = 1'b0; ib.instr_valid = 1'b1;
        ib.instr = 32'h00100093; step();
        ib.instr = 32'h00200113; step();
        #3 check("bp_rdy_low", 32'(ib.instr_ready), 32'd0);
        ib.instr = 32'h00300193; step();
        #3 check("bp_rdy_held", 32'(ib.instr_ready), 32'd0);
        check("bp_head1", ob.alu_rs2, 32'd1);
        ob.alu_ready = 1'b1; step();
        #3 check("bp_head2", ob.alu_rs2, 32'd2);
        step();
        #3 check("bp_head3", ob.alu_rs2, 32'd3);
        ib.instr_valid = 1'b0; step();
        #3 check("bp_drained", 32'(ob.alu_valid), 32'd0);

        // Flush while FULL, then flush while ONE where the transfer would otherwise land.
        ob.alu_ready = 1'b0; ib.instr_valid = 1'b1;
        ib.instr = 32'h00400213; step();
        ib.instr = 32'h00500293; step();
        ib.instr = 32'h00600313; flush = 1'b1; step();
        flush = 1'b0;
        #3 check("flush_full_valid", 32'(ob.alu_valid), 32'd0);
        check("flush_full_ready", 32'(ib.instr_ready), 32'd1);
        ib.instr = 32'h00700393; step();
        ib.instr = 32'h00800413; flush = 1'b1; step();
        flush = 1'b0; ib.instr_valid = 1'b0;
        #3 check("flush_one_valid", 32'(ob.alu_valid), 32'd0);
        step();
        #3 check("flush_one_dropped", 32'(ob.alu_valid), 32'd0);

        // Reset while FULL with an instruction pending.
        ib.instr_valid = 1'b1;
        ib.instr = 32'h00900493; step();
        ib.instr = 32'h00A00513; step();
        ib.instr = 32'h00B00593; rst = 1'b1; step();
        rst = 1'b0; ib.instr_valid = 1'b0;
        #3 check_reset_vals("rst_full");
        step();

        // Randomized traffic with backpressure and occasional flushes.
        for (int n = 0; n < 600; n++) begin
            ib.instr_valid = ($urandom_range(0, 9) < 7);
            ib.instr       = rand_instr();
            ib.pc          = $urandom & 32'hFFFF_FFFC;
            ib.rs1_data    = $urandom;
            ib.rs2_data    = $urandom;
            ob.alu_ready   = ($urandom_range(0, 9) < 6);
            flush          = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0; ib.instr_valid = 1'b0; ob.alu_ready = 1'b1;
        repeat (4) step();
        check("final_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_alu_decoder.md
# rv32_alu_decoder

- Registered decode stage that turns a 32-bit RV32I instruction plus its register-file read data into one ALU issue packet for `rv32_alu`.
- Issue packet: ALU opcode, operand A, operand B, destination register, branch offset and flags.
- Sits between instruction fetch/register read and the ALU.
- Valid/ready on both sides, with a 2-entry buffer so that `instr_ready` is driven directly from a flop.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous; discards all buffered packets.
- `instr_valid` in 1: instruction and operands valid.
- `instr_ready` out 1: stage can accept; driven from a flop.
- `instr` in 32: instruction word.
- `pc` in 32: instruction address.
- `rs1_data` in 32: register-file value for `instr[19:15]`.
- `rs2_data` in 32: register-file value for `instr[24:20]`.
- `alu_valid` out 1: packet valid.
- `alu_ready` in 1: ALU side consumes the packet.
- `alu_opcode` out `rv32_alu_op_t`: `ALU_*` code.
- `alu_rs1` out 32: operand A.
- `alu_rs2` out 32: operand B.
- `rd` out 5: destination register; 0 for branches.
- `br_offset` out 32: sign-extended B-type immediate; 0 otherwise.
- `is_branch` out 1: packet is a conditional branch.
- `illegal` out 1: instruction not decodable; packet still issued with `ALU_ADD`, operands 0, `rd` = 0.

## Operation
Decode is combinational on the input and registered on acceptance. Operand A is `rs1_data` unless stated otherwise.

- OP (0110011), funct7 must be 0x00 or 0x20, any other funct7 is illegal:
  - funct3 → opcode: 000 → ADD, or SUB when funct7 = 0x20; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7 = 0x20; 110 OR; 111 AND.
  - Operand B = `rs2_data`.
  - funct7 = 0x20 with funct3 other than 000/101 is illegal.
- OP-IMM (0010011):
  - Same funct3 map; there is no SUB.
  - Operand B = sign-extended `instr[31:20]`.
  - Shifts (funct3 001/101): B = zero-extended shamt `instr[24:20]`. `instr[31:25]` must be 0x00, or 0x20 for SRAI; anything else is illegal.
- LUI (0110111): ADD, A = 0, B = `{instr[31:12], 12'b0}`.
- AUIPC (0010111): ADD, A = `pc`, B = `{instr[31:12], 12'b0}`.
- BRANCH (1100011):
  - funct3 → opcode: 000 EQ, 001 NEQ, 100 SLT, 101 SBT, 110 SLTU, 111 SBTU; 010/011 are illegal.
  - B = `rs2_data`, `is_branch` = 1, `rd` = 0, `br_offset` = `{{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}`.
- Any other major opcode, or `instr[1:0]` ≠ 11: illegal.

Buffering:
- Two entries: OUT, which drives the `alu_*` outputs, and SKID.
- States, encoded by entry occupancy:
  - EMPTY: OUT empty.
  - ONE: OUT full, SKID empty.
  - FULL: both entries full.
- `instr_ready` = 1 in EMPTY and ONE, 0 in FULL; it is registered.
- A transfer occurs on `instr_valid & instr_ready`; a consume occurs on `alu_valid & alu_ready`.
- Transitions:
  - EMPTY + transfer → ONE.
  - ONE + transfer + consume → ONE; OUT reloads with the new packet.
  - ONE + transfer, no consume → FULL; the new packet goes to SKID.
  - ONE + consume, no transfer → EMPTY.
  - FULL + consume → ONE; SKID moves to OUT.
- Order is strictly FIFO; no packet is ever dropped or duplicated except by `flush`/`rst`.
- `flush` has priority over everything:
  - Next state is EMPTY and `instr_ready` = 1.
  - A transfer in the flush cycle is discarded.
  - A consume in the flush cycle still counts for the ALU side.

## Timing
- Latency: an instruction accepted in cycle N is presented on the `alu_*` outputs in cycle N+1 when OUT is empty or consumed that cycle; otherwise it waits behind the older packet.
- Throughput: 1 instruction per cycle while `alu_ready` = 1.
- Output stability: `alu_*` outputs hold stable while `alu_valid & !alu_ready`.
- Reset values: `alu_valid` = 0, `instr_ready` = 1, `alu_opcode` = `ALU_ADD`, `alu_rs1`/`alu_rs2`/`br_offset` = 0, `rd` = 0, `is_branch` = 0, `illegal` = 0.
- Reset mid-operation discards both entries; no packet is issued.
- Payload registers update only on load, so reducing toggle activity is optional.

## Test plan
- Directed decode, one per cycle with `alu_ready` = 1, rs1_data = 0x10, rs2_data = 0x3:
  - `0x002081B3` → ADD, rd 3.
  - `0x402081B3` → SUB.
  - `0xFFF08293` → ADD, B = 0xFFFFFFFF, rd 5.
  - `0x4030D293` → SRA, B = 3.
  - Each packet appears 1 cycle after acceptance, back-to-back.
- Upper immediates, pc = 0x100:
  - `0x123453B7` → ADD, A = 0, B = 0x12345000, rd 7.
  - `0x12345397` → A = 0x100, B = 0x12345000.
- Branch `0x00208463`: EQ, `is_branch` = 1, `br_offset` = 8, rd = 0.
  - Same instruction with funct3 = 101 → SBT.
- Illegal:
  - `0x00000000` → `illegal` = 1, ADD, operands 0.
  - `0x02208233` (funct7 = 0x01) → `illegal` = 1.
- Backpressure:
  - Hold `alu_ready` = 0 and stream 3 instructions.
  - Expect `instr_ready` low 1 cycle after the 2nd acceptance; the 3rd is held at the input.
  - Release `alu_ready` → packets issue in order 1, 2, 3 with no loss.
- Flush/reset in state FULL with `instr_valid` = 1:
  - Next cycle `alu_valid` = 0 and `instr_ready` = 1.
  - The input from the flush cycle is never issued.
  - Repeat with `rst`; all outputs equal their reset values.
